// File: rtl/hwpe_seq_pkg.sv
// Shared types for the job sequencer: FSM states and the queued command entry.
// Widths here must match the sequencer's ADDR_WIDTH/DATA_WIDTH parameters.
package hwpe_seq_pkg;

  localparam int JOBS_CNT_W = 16;
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RESP,
    NEXT,
    WAIT_EVT,
    DONE
  } state_e;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
    logic                  last;
  } cmd_t;

endpackage

// File: rtl/hwpe_job_sequencer_if.sv
// Command push channel from the FC bridge plus the accelerator periph write port.
// The sequencer takes the slave view; the FC/accelerator environment takes master.
interface hwpe_job_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_last;

  logic                  per_req;
  logic [ADDR_WIDTH-1:0] per_add;
  logic                  per_we;
  logic [3:0]            per_be;
  logic [DATA_WIDTH-1:0] per_wdata;
  logic                  per_gnt;
  logic                  per_r_valid;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, cmd_last, per_gnt, per_r_valid,
    output cmd_ready, per_req, per_add, per_we, per_be, per_wdata
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_data, cmd_last, per_gnt, per_r_valid,
    input  cmd_ready, per_req, per_add, per_we, per_be, per_wdata
  );

endinterface

// File: rtl/hwpe_seq_fifo.sv
// Synchronous FIFO of cmd_t, registered head read, no bypass.
// A push while full is accepted only if a pop happens in the same cycle.
module hwpe_seq_fifo
  import hwpe_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  cmd_t push_dat_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          wr_fire;
  logic          rd_fire;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem[rd_ptr_q];

  assign wr_fire = push_i && (!full_o || pop_i);
  assign rd_fire = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed behind the count.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/hwpe_job_sequencer.sv
// Replays queued register writes to the accelerator cfg port, one outstanding at a time;
// push-to-request latency 2 cycles, cmd_ready drops only when the FIFO is full.
module hwpe_job_sequencer
  import hwpe_seq_pkg::*;
#(
  parameter int CMD_DEPTH  = 8,
  parameter int ADDR_WIDTH = CMD_ADDR_W,
  parameter int DATA_WIDTH = CMD_DATA_W,
  parameter int TMO_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hwpe_job_sequencer_if.slave   bus,
  input  logic [TMO_WIDTH-1:0]  tmo_limit_i,
  input  logic                  err_clr_i,
  input  logic                  acc_evt_i,
  output logic                  busy_o,
  output logic                  job_done_o,
  output logic                  tmo_err_o,
  output logic [JOBS_CNT_W-1:0] jobs_cnt_o
);

  state_e                state_q;
  state_e                state_d;

  cmd_t                  push_dat;
  cmd_t                  head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  logic [ADDR_WIDTH-1:0] add_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  last_q;
  logic [TMO_WIDTH-1:0]  tmo_cnt_q;
  logic                  evt_seen_q;
  logic                  tmo_err_q;
  logic                  timed_out_q;
  logic [JOBS_CNT_W-1:0] jobs_cnt_q;

  logic                  evt_hit;
  logic                  tmo_hit;
  logic                  evt_window;

  assign push     = bus.cmd_valid && bus.cmd_ready;
  assign push_dat = '{addr: bus.cmd_addr, data: bus.cmd_data, last: bus.cmd_last};

  hwpe_seq_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // An event arriving in the same cycle as the timeout wins.
  assign evt_hit = evt_seen_q || acc_evt_i;
  assign tmo_hit = (state_q == WAIT_EVT) && !evt_hit && (tmo_limit_i != '0) &&
                   (tmo_cnt_q == tmo_limit_i - TMO_WIDTH'(1));

  // Events are captured from the trigger write's grant onward so a fast
  // accelerator finishing during RESP is not missed.
  assign evt_window = ((state_q == ISSUE) && bus.per_gnt && last_q) ||
                      ((state_q == RESP) && last_q) ||
                      (state_q == WAIT_EVT);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE, NEXT: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:    if (bus.per_gnt) state_d = RESP;
      RESP:     if (bus.per_r_valid) state_d = last_q ? WAIT_EVT : NEXT;
      WAIT_EVT: if (evt_hit || tmo_hit) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      add_q       <= '0;
      wdata_q     <= '0;
      last_q      <= 1'b0;
      tmo_cnt_q   <= '0;
      evt_seen_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
      timed_out_q <= 1'b0;
      jobs_cnt_q  <= '0;
    end else begin
      if (pop) begin
        add_q   <= head.addr;
        wdata_q <= head.data;
        last_q  <= head.last;
      end

      if (state_q == WAIT_EVT)  tmo_cnt_q <= tmo_cnt_q + TMO_WIDTH'(1);
      else if (state_q == DONE) tmo_cnt_q <= '0;

      if (state_q == DONE)               evt_seen_q <= 1'b0;
      else if (evt_window && acc_evt_i)  evt_seen_q <= 1'b1;

      // A fresh timeout beats a simultaneous clear of the sticky flag.
      if (tmo_hit) begin
        tmo_err_q   <= 1'b1;
        timed_out_q <= 1'b1;
      end else begin
        if (err_clr_i)        tmo_err_q   <= 1'b0;
        if (state_q == DONE)  timed_out_q <= 1'b0;
      end

      if ((state_q == DONE) && !timed_out_q) jobs_cnt_q <= jobs_cnt_q + JOBS_CNT_W'(1);
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.per_req   = (state_q == ISSUE);
  assign bus.per_add   = add_q;
  assign bus.per_we    = 1'b1;
  assign bus.per_be    = 4'hF;
  assign bus.per_wdata = wdata_q;

  assign busy_o     = (state_q != IDLE) || !fifo_empty;
  assign job_done_o = (state_q == DONE);
  assign tmo_err_o  = tmo_err_q;
  assign jobs_cnt_o = jobs_cnt_q;

endmodule
